palette_port_arbiter: RTL
=========================

// Module: palette_port_arbiter
// PURPOSE
//  Shares the single 512-entry palette lookup (9-bit index -> 4/4/4 RGB) among NUM_REQ
//  requesters: player, bubbles, harpoon and background sprite fetchers.
//  - Arbitrates round-robin and drives the palette index from a register.
//  - Captures the palette colour and returns it with a requester tag and a transparency flag.
//  - Sits between the sprite fetch units and the pixel compositor.
// PARAMETERS
//  NUM_REQ     4      number of requesters (2..8)
//  IDX_W       9      palette index width
//  COLOR_W     4      bits per colour channel
//  TRANSP_IDX  9'd0   index treated as transparent (rsp_transp=1)
// PORTS
//  clk         in   1                 system clock, rising edge
//  reset_n     in   1                 asynchronous, active-low reset
//  req_valid   in   NUM_REQ           request strobe per requester
//  req_index   in   NUM_REQ x IDX_W   palette index per requester
//  req_ready   out  NUM_REQ           one-hot grant; the transfer completes when valid&ready
//  pal_index   out  IDX_W             registered index to the palette lookup
//  pal_red     in   COLOR_W           palette colour returned for pal_index (combinational)
//  pal_green   in   COLOR_W           "
//  pal_blue    in   COLOR_W           "
//  rsp_valid   out  1                 response holds a colour
//  rsp_ready   in   1                 compositor accepts the response
//  rsp_id      out  $clog2(NUM_REQ)   requester that owns the response
//  rsp_red     out  COLOR_W           captured colour
//  rsp_green   out  COLOR_W           "
//  rsp_blue    out  COLOR_W           "
//  rsp_transp  out  1                 1 when the looked-up index == TRANSP_IDX
// BEHAVIOUR
//  - Reset (asynchronous, takes effect immediately, including mid-operation):
//    - req_ready=0, pal_index=0, rsp_valid=0, rsp_id=0, rsp_red/green/blue=0, rsp_transp=0.
//    - Both stage-valid bits clear and all in-flight lookups are discarded.
//    - rr_ptr=NUM_REQ-1, so requester 0 wins first.
//  - Pipeline: two stages.
//    - Stage A: grant register holding idx, id and a_valid; drives pal_index.
//    - Stage B: response register.
//    - Latency is 2 cycles from the accept edge to rsp_valid=1.
//    - Throughput is 1 lookup per cycle when rsp_ready=1.
//  - Flow control:
//    - b_free = !rsp_valid | rsp_ready.
//    - a_free = !a_valid | b_free.
//    - req_ready[i]=1 only for the round-robin winner among req_valid, and only when a_free.
//      It is combinational and asserts in the same cycle as req_valid.
//  - Arbitration: search starts at rr_ptr+1 modulo NUM_REQ; the first valid requester wins.
//    - rr_ptr updates to the winner only on an accepted transfer.
//    - A stall freezes rr_ptr, so a waiting requester keeps its priority.
//  - Stage A update (accept): a_idx<=req_index[w], a_id<=w, a_valid<=1.
//    - If a_free and no request: a_valid<=0.
//  - Stage B update (a_valid & b_free): capture pal_red/green/blue, a_id, and
//    (a_idx==TRANSP_IDX); rsp_valid<=1.
//    - If b_free and !a_valid: rsp_valid<=0.
//  - Response stability: rsp_* is held bit-stable while rsp_valid & !rsp_ready.
//    pal_index is also held, so the palette output is stable.
//  - Simultaneous drain and fill: rsp_ready with a_valid moves A->B and accepts a new request
//    in the same cycle; no bubble is inserted.
//  - Requester rule: req_index is held stable while req_valid & !req_ready.
//    A requester may drop req_valid before it is granted; nothing is recorded for it.
//  - A single requester asserting continuously is granted every cycle.
//    With all requesters valid, grants cycle 0,1,2,3,0,...
// STRUCTURE
//  - palette_pkg:
//    - rgb_t struct {r,g,b} of COLOR_W bits each.
//    - PAL_IDX_W=9 and PAL_TRANSP_IDX=0 constants.
//    - Requester id enum: REQ_BG=0, REQ_PLAYER=1, REQ_BUBBLE=2, REQ_HARPOON=3.
//  - rr_arbiter sub-module (parameter N):
//    - Inputs: req vector, rr_ptr, enable.
//    - Outputs: one-hot grant and a binary winner id.
//  - Pipeline registers and flow control stay in palette_port_arbiter.
// TESTING (bench instantiates the real palette behind pal_*)
//  1. Reset release; req0 valid with idx 1, rsp_ready=1.
//     -> req_ready[0] in that cycle; 2 cycles later rsp_valid=1, id=0, RGB=F/F/F, transp=0.
//  2. All 4 valid with idx 2,18,19,0 held and rsp_ready=1.
//     -> grants in order 0,1,2,3,0.
//     -> responses E/5/6, F/0/3, 0/0/0, 1/A/C with transp=1 on id 3.
//  3. rsp_ready=0 for 5 cycles while req1 streams.
//     -> exactly 2 requests are accepted, then req_ready=0.
//     -> rsp_* is stable for all 5 cycles.
//     -> on release, responses arrive in order with no loss or duplicates.
//  4. req2 and req3 valid; after req2 is granted, rsp_ready toggles 1,0,1.
//     -> rr_ptr freezes during the stall and req3 is granted next.
//  5. reset_n asserted mid-stream with both stages full.
//     -> all outputs go to 0 before the next edge.
//     -> after release, the first grant goes to req0.
//  6. req0 alone valid for 8 cycles, rsp_ready=1.
//     -> 8 consecutive grants and 8 back-to-back responses with no bubbles.

Source files
------------

// File: rtl/palette_port_arbiter_pkg.sv
// Shared types and constants for the palette port arbiter: colour triple, index width,
// transparent index and the fixed requester numbering.
package palette_port_arbiter_pkg;

  localparam int unsigned PAL_IDX_W   = 9;
  localparam int unsigned PAL_COLOR_W = 4;

  localparam logic [PAL_IDX_W-1:0] PAL_TRANSP_IDX = '0;

  typedef struct packed {
    logic [PAL_COLOR_W-1:0] r;
    logic [PAL_COLOR_W-1:0] g;
    logic [PAL_COLOR_W-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    REQ_BG      = 2'd0,
    REQ_PLAYER  = 2'd1,
    REQ_BUBBLE  = 2'd2,
    REQ_HARPOON = 2'd3
  } req_id_e;

endpackage

// File: rtl/palette_port_arbiter_if.sv
// Bus bundle between the sprite fetchers, the palette lookup and the compositor.
// The arbiter uses the slave modport; the surrounding system drives the master side.
interface palette_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 9,
  parameter int unsigned COLOR_W = 4
);

  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][IDX_W-1:0] req_index;
  logic [NUM_REQ-1:0]            req_ready;

  logic [IDX_W-1:0]   pal_index;
  logic [COLOR_W-1:0] pal_red;
  logic [COLOR_W-1:0] pal_green;
  logic [COLOR_W-1:0] pal_blue;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [IdW-1:0]     rsp_id;
  logic [COLOR_W-1:0] rsp_red;
  logic [COLOR_W-1:0] rsp_green;
  logic [COLOR_W-1:0] rsp_blue;
  logic               rsp_transp;

  modport slave (
    input  req_valid,
    input  req_index,
    output req_ready,
    output pal_index,
    input  pal_red,
    input  pal_green,
    input  pal_blue,
    output rsp_valid,
    input  rsp_ready,
    output rsp_id,
    output rsp_red,
    output rsp_green,
    output rsp_blue,
    output rsp_transp
  );

  modport master (
    output req_valid,
    output req_index,
    input  req_ready,
    input  pal_index,
    output pal_red,
    output pal_green,
    output pal_blue,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_id,
    input  rsp_red,
    input  rsp_green,
    input  rsp_blue,
    input  rsp_transp
  );

endinterface

// File: rtl/palette_port_arbiter_rr.sv
// Round-robin picker: searches upward from rr_ptr_i+1 (wrapping) for the first active request.
// The winner id is always produced; the one-hot grant only when enabled.
module palette_port_arbiter_rr #(
  parameter  int unsigned N   = 4,
  localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] rr_ptr_i,
  input  logic           en_i,
  output logic [N-1:0]   gnt_o,
  output logic [IdW-1:0] id_o,
  output logic           any_o
);

  logic [IdW-1:0] cand;

  always_comb begin
    any_o = 1'b0;
    id_o  = '0;
    cand  = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = IdW'((32'(rr_ptr_i) + off) % N);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        id_o  = cand;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (any_o && en_i) begin
      gnt_o[id_o] = 1'b1;
    end
  end

endmodule

// File: rtl/palette_port_arbiter.sv
// Shares one palette lookup among NUM_REQ sprite fetchers: round-robin grant into a registered
// index stage (A), then a response stage (B) capturing colour, owner id and transparency.
module palette_port_arbiter
  import palette_port_arbiter_pkg::*;
#(
  parameter int unsigned      NUM_REQ    = 4,
  parameter int unsigned      IDX_W      = PAL_IDX_W,
  parameter int unsigned      COLOR_W    = PAL_COLOR_W,
  parameter logic [IDX_W-1:0] TRANSP_IDX = IDX_W'(PAL_TRANSP_IDX)
) (
  input logic                    clk,
  input logic                    reset_n,
  palette_port_arbiter_if.slave  bus_io
);

  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic               a_valid_q, a_valid_d;
  logic [IDX_W-1:0]   a_idx_q, a_idx_d;
  logic [IdW-1:0]     a_id_q, a_id_d;
  logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;

  logic               rsp_valid_q, rsp_valid_d;
  logic [IdW-1:0]     rsp_id_q, rsp_id_d;
  logic [COLOR_W-1:0] rsp_red_q, rsp_red_d;
  logic [COLOR_W-1:0] rsp_green_q, rsp_green_d;
  logic [COLOR_W-1:0] rsp_blue_q, rsp_blue_d;
  logic               rsp_transp_q, rsp_transp_d;

  logic               b_free;
  logic               a_free;
  logic               any_req;
  logic               accept;
  logic [IdW-1:0]     win_id;
  logic [NUM_REQ-1:0] gnt;

  assign b_free = !rsp_valid_q || bus_io.rsp_ready;
  assign a_free = !a_valid_q || b_free;
  // Gate with reset so no grant is offered while the pipeline is held cleared.
  assign accept = any_req && a_free && reset_n;

  palette_port_arbiter_rr #(
    .N (NUM_REQ)
  ) u_rr (
    .req_i    (bus_io.req_valid),
    .rr_ptr_i (rr_ptr_q),
    .en_i     (a_free && reset_n),
    .gnt_o    (gnt),
    .id_o     (win_id),
    .any_o    (any_req)
  );

  // Stage A and round-robin pointer; a stall leaves both untouched.
  always_comb begin
    a_valid_d = a_valid_q;
    a_idx_d   = a_idx_q;
    a_id_d    = a_id_q;
    rr_ptr_d  = rr_ptr_q;
    if (a_free) begin
      a_valid_d = accept;
      if (accept) begin
        a_idx_d  = bus_io.req_index[win_id];
        a_id_d   = win_id;
        rr_ptr_d = win_id;
      end
    end
  end

  // Stage B: capture the palette output for the index currently held in stage A.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_red_d    = rsp_red_q;
    rsp_green_d  = rsp_green_q;
    rsp_blue_d   = rsp_blue_q;
    rsp_transp_d = rsp_transp_q;
    if (b_free) begin
      rsp_valid_d = a_valid_q;
      if (a_valid_q) begin
        rsp_id_d     = a_id_q;
        rsp_red_d    = bus_io.pal_red;
        rsp_green_d  = bus_io.pal_green;
        rsp_blue_d   = bus_io.pal_blue;
        rsp_transp_d = (a_idx_q == TRANSP_IDX);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_valid_q    <= 1'b0;
      a_idx_q      <= '0;
      a_id_q       <= '0;
      rr_ptr_q     <= IdW'(NUM_REQ - 1);
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_red_q    <= '0;
      rsp_green_q  <= '0;
      rsp_blue_q   <= '0;
      rsp_transp_q <= 1'b0;
    end else begin
      a_valid_q    <= a_valid_d;
      a_idx_q      <= a_idx_d;
      a_id_q       <= a_id_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_red_q    <= rsp_red_d;
      rsp_green_q  <= rsp_green_d;
      rsp_blue_q   <= rsp_blue_d;
      rsp_transp_q <= rsp_transp_d;
    end
  end

  assign bus_io.req_ready  = gnt;
  assign bus_io.pal_index  = a_idx_q;
  assign bus_io.rsp_valid  = rsp_valid_q;
  assign bus_io.rsp_id     = rsp_id_q;
  assign bus_io.rsp_red    = rsp_red_q;
  assign bus_io.rsp_green  = rsp_green_q;
  assign bus_io.rsp_blue   = rsp_blue_q;
  assign bus_io.rsp_transp = rsp_transp_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(bus_io.req_ready));

  a_rsp_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (rsp_valid_q && !bus_io.rsp_ready) |=>
      (rsp_valid_q && $stable({rsp_id_q, rsp_red_q, rsp_green_q, rsp_blue_q, rsp_transp_q})));

endmodule
